crypto_bus_arbiter: RTL and testbench

CRYPTO_BUS_ARBITER -- requirements
Module: crypto_bus_arbiter

---
 rtl/crypto_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_crypto_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/crypto_bus_arbiter.sv
// Four-requester round-robin arbiter in front of a 16-slot, 448-bit register file.
// Optional macro ARB_BURST_LIMIT_EN caps a locked burst at BURST_MAX transactions.
module crypto_bus_arbiter #(
    parameter int BURST_MAX = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   we,
    input  logic [3:0]   lock,
    input  logic [3:0]   addr0,
    input  logic [3:0]   addr1,
    input  logic [3:0]   addr2,
    input  logic [3:0]   addr3,
    input  logic [447:0] wdata0,
    input  logic [447:0] wdata1,
    input  logic [447:0] wdata2,
    input  logic [447:0] wdata3,
    input  logic [447:0] dataOut,
    output logic [3:0]   selectRead,
    output logic [15:0]  writeEnable,
    output logic [447:0] writeBus,
    output logic [3:0]   ack,
    output logic [447:0] rdata,
    output logic         busy,
    output logic [1:0]   grantId
);

    // Handshake: req[i] is a level request; the requester holds req/we/addr/wdata
    // until ack[i] pulses for one cycle. Once latched, a transaction always completes.
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t       state;
    logic [1:0]   rr_ptr;
    logic         lat_we;
    logic [1:0]   win_idx;
    logic         win_valid;
    logic [1:0]   sel_idx;
    logic [3:0]   sel_addr;
    logic [447:0] sel_wdata;
    logic         sel_we;
    logic         burst_ok;
    logic         burst_go;
    logic         do_latch;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[rr_ptr + 2'(k)]) begin
                win_valid = 1'b1;
                win_idx   = rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        sel_idx = (state == DONE) ? grantId : win_idx;
        case (sel_idx)
            2'd0:    begin sel_addr = addr0; sel_wdata = wdata0; end
            2'd1:    begin sel_addr = addr1; sel_wdata = wdata1; end
            2'd2:    begin sel_addr = addr2; sel_wdata = wdata2; end
            default: begin sel_addr = addr3; sel_wdata = wdata3; end
        endcase
        sel_we = we[sel_idx];
    end

`ifdef ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(BURST_MAX + 1);
    logic [CW-1:0] burst_cnt;

    // burst_cnt holds the number of transactions already completed in this burst.
    assign burst_ok = (32'(burst_cnt) + 32'd1) < BURST_MAX;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (state == DONE) begin
            if (burst_go) burst_cnt <= burst_cnt + CW'(1);
            else          burst_cnt <= '0;
        end
    end
`else
    assign burst_ok = 1'b1;
`endif

    assign burst_go = (state == DONE) && lock[grantId] && req[grantId] && burst_ok;
    assign do_latch = ((state == IDLE) && win_valid) || burst_go;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 2'd0;
            grantId     <= 2'd0;
            lat_we      <= 1'b0;
            busy        <= 1'b0;
            ack         <= 4'd0;
            writeEnable <= 16'd0;
            writeBus    <= '0;
            selectRead  <= 4'd0;
            rdata       <= '0;
        end else begin
            ack <= 4'd0;
            if (state == DONE) rr_ptr <= grantId + 2'd1;
            if (do_latch) begin
                grantId     <= sel_idx;
                lat_we      <= sel_we;
                selectRead  <= sel_addr;
                writeEnable <= sel_we ? (16'd1 << sel_addr) : 16'd0;
                writeBus    <= sel_we ? sel_wdata : '0;
                busy        <= 1'b1;
                state       <= ACCESS;
            end else begin
                case (state)
                    ACCESS: begin
                        writeEnable <= 16'd0;
                        writeBus    <= '0;
                        if (!lat_we) rdata <= dataOut;
                        ack         <= 4'd1 << grantId;
                        state       <= DONE;
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crypto_bus_arbiter.sv
// Scoreboard bench for crypto_bus_arbiter: directed vectors, expected acks and
// write strobes queued at issue time and compared by an independent monitor.
module tb_crypto_bus_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   req, we, lock;
    logic [3:0]   addr [4];
    logic [447:0] wdata [4];
    logic [447:0] dataOut;
    logic [3:0]   selectRead;
    logic [15:0]  writeEnable;
    logic [447:0] writeBus;
    logic [3:0]   ack;
    logic [447:0] rdata;
    logic         busy;
    logic [1:0]   grantId;

    logic [449:0] exp_q [$];
    logic [451:0] wexp_q [$];
    logic [447:0] model_rdata;
    int checks = 0;
    int errors = 0;

    crypto_bus_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .lock(lock),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
        .wdata0(wdata[0]), .wdata1(wdata[1]), .wdata2(wdata[2]), .wdata3(wdata[3]),
        .dataOut(dataOut), .selectRead(selectRead), .writeEnable(writeEnable),
        .writeBus(writeBus), .ack(ack), .rdata(rdata), .busy(busy), .grantId(grantId)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [447:0] got, input logic [447:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] bit_index(input logic [15:0] v);
        bit_index = 4'd0;
        for (int i = 0; i < 16; i++) if (v[i]) bit_index = 4'(i);
    endfunction

    // Monitor: pops expectations whenever the DUT presents an ack or a write strobe.
    always @(negedge clock) begin
        if (!reset) begin
            if (ack != 4'd0) begin
                checks++;
                if (!$onehot(ack) || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected ack=%b pending=%0d", ack, exp_q.size());
                end else begin
                    logic [449:0] e;
                    e = exp_q.pop_front();
                    check("ack_id_rdata", {bit_index({12'd0, ack}), rdata}, e);
                end
            end
            if (writeEnable != 16'd0) begin
                checks++;
                if (!$onehot(writeEnable) || wexp_q.size() == 0) begin
                    errors++;
                    $display("FAIL we_unexpected writeEnable=%h pending=%0d", writeEnable, wexp_q.size());
                end else begin
                    logic [451:0] w;
                    w = wexp_q.pop_front();
                    check("write_slot_data", {bit_index(writeEnable), writeBus}, w);
                end
            end else if (writeBus != '0) begin
                checks++;
                errors++;
                $display("FAIL writebus_idle got=%0h exp=0", writeBus);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 20) begin @(negedge clock); n++; end
        if (busy) check("idle_timeout", 448'(busy), 448'd0);
    endtask

    task automatic do_req(input int idx, input logic w, input logic [3:0] a, input logic [447:0] d);
        int n;
        bit got;
        wait_idle();
        req[idx] = 1'b1; we[idx] = w; addr[idx] = a; wdata[idx] = d;
        if (w) wexp_q.push_back({a, d});
        else   model_rdata = dataOut;
        exp_q.push_back({2'(idx), model_rdata});
        @(posedge clock); #1;
        check("select_read", 448'(selectRead), 448'(a));
        n = 1; got = 0;
        while (n < 20 && !got) begin
            @(posedge clock); #1; n++;
            if (ack[idx]) got = 1;
        end
        req[idx] = 1'b0; we[idx] = 1'b0;
        check("ack_latency", 448'(n), 448'd2);
    endtask

    initial begin
        int n, c0, c1;
        req = '0; we = '0; lock = '0; dataOut = '0; model_rdata = '0;
        for (int i = 0; i < 4; i++) begin addr[i] = '0; wdata[i] = '0; end
        reset = 1'b1;
        #2;
        check("reset_busy", 448'(busy), 448'd0);
        check("reset_ack_we", 448'({ack, writeEnable}), 448'd0);
        check("reset_grant_sel", 448'({grantId, selectRead}), 448'd0);
        check("reset_bus_rdata", writeBus | rdata, 448'd0);
        @(negedge clock); reset = 1'b0;

        // All four request at once with rrPtr=0: grants 0,1,2,3,0.
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            addr[i] = 4'(8 + i); wdata[i] = 448'(100 + i); we[i] = 1'b1;
        end
        foreach (addr[g]) begin
            wexp_q.push_back({addr[g], wdata[g]});
            exp_q.push_back({2'(g), model_rdata});
        end
        wexp_q.push_back({addr[0], wdata[0]});
        exp_q.push_back({2'd0, model_rdata});
        req = 4'b1111;
        n = 0; c0 = 0;
        while (n < 60 && c0 < 5) begin
            @(posedge clock); #1; n++;
            if (ack != 4'd0) c0++;
        end
        req = '0; we = '0;
        check("rr_ack_count", 448'(c0), 448'd5);

        do_req(0, 1'b1, 4'd5, 448'hA5);
        dataOut = 448'h1234;
        do_req(2, 1'b0, 4'd3, 448'h0);
        dataOut = 448'hBEEF_0000_CAFE;
        do_req(3, 1'b0, 4'd7, 448'h0);
        dataOut = 448'h5555;
        do_req(1, 1'b1, 4'd15, 448'hDEAD);
        check("rdata_hold_after_write", rdata, 448'hBEEF_0000_CAFE);

        // Locked burst by requester 1 while requester 0 waits.
        wait_idle();
        addr[1] = 4'd2; wdata[1] = 448'h11; we[1] = 1'b1; lock[1] = 1'b1;
        addr[0] = 4'd1; wdata[0] = 448'h22; we[0] = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
        for (int i = 0; i < 21; i++) begin
            if (i == 8) begin
                wexp_q.push_back({4'd1, 448'h22}); exp_q.push_back({2'd0, model_rdata});
            end else begin
                wexp_q.push_back({4'd2, 448'h11}); exp_q.push_back({2'd1, model_rdata});
            end
        end
`else
        for (int i = 0; i < 20; i++) begin
            wexp_q.push_back({4'd2, 448'h11}); exp_q.push_back({2'd1, model_rdata});
        end
        wexp_q.push_back({4'd1, 448'h22}); exp_q.push_back({2'd0, model_rdata});
`endif
        req[1] = 1'b1;
        @(negedge clock);
        req[0] = 1'b1;
        n = 0; c0 = 0; c1 = 0;
        while (n < 300 && c1 < 20) begin
            @(posedge clock); #1; n++;
            if (ack[1]) c1++;
            if (ack[0]) begin c0++; req[0] = 1'b0; end
        end
        req[1] = 1'b0; lock[1] = 1'b0; we[1] = 1'b0;
        check("burst_owner_count", 448'(c1), 448'd20);
`ifdef ARB_BURST_LIMIT_EN
        check("burst_limit_grant0", 448'(c0), 448'd1);
`else
        check("burst_no_grant0", 448'(c0), 448'd0);
        n = 0;
        while (n < 20 && c0 == 0) begin
            @(posedge clock); #1; n++;
            if (ack[0]) c0++;
        end
        req[0] = 1'b0;
        check("grant0_after_unlock", 448'(c0), 448'd1);
`endif
        we[0] = 1'b0;

        // Reset pulse during a write's ACCESS cycle aborts it without an ack.
        wait_idle();
        req[3] = 1'b1; we[3] = 1'b1; addr[3] = 4'd9; wdata[3] = 448'h99;
        wexp_q.push_back({4'd9, 448'h99});
        @(posedge clock); #6;
        reset = 1'b1;
        #1;
        check("abort_we_cleared", 448'(writeEnable), 448'd0);
        check("abort_busy_ack", 448'({busy, ack}), 448'd0);
        req = '0; we = '0;
        #1 reset = 1'b0;
        model_rdata = '0;
        repeat (5) @(posedge clock);
        #1 check("abort_no_ack_rdata", rdata, 448'd0);
        do_req(2, 1'b1, 4'd4, 448'h4242);

        repeat (3) @(negedge clock);
        check("exp_q_drained", 448'(exp_q.size()), 448'd0);
        check("wexp_q_drained", 448'(wexp_q.size()), 448'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
